// File: rtl/cw_deserializer.sv
// Serial-to-parallel front end for the (31,16) burst-error-correcting decoder.
// Collects sof-aligned channel bits into N-bit codewords behind a one-entry valid/ready output register.
module cw_deserializer #(
    parameter int N  = 31,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin_valid,
    input  logic         sin_data,
    input  logic         sin_sof,
    output logic         cw_valid,
    input  logic         cw_ready,
    output logic [0:N-1] cw_data,
    output logic         overflow,
    output logic         sync_err
);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam logic [CW-1:0] IDX_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] IDX_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);

    state_t         state_r;
    logic [CW-1:0]  idx_r;
    logic [0:N-1]   frame_r;
    logic [0:N-1]   cw_data_r;
    logic           cw_valid_r;
    logic           overflow_r;
    logic           sync_err_r;

    logic [0:N-1]   word_s;
    logic           complete_s;
    logic           handshake_s;
    logic           load_s;
    logic           drop_s;

    // Completed word includes the final bit arriving this cycle, so it can load at the same edge.
    always_comb begin
        word_s        = frame_r;
        word_s[idx_r] = sin_data;
    end

    // Frame completion and output-register admission decisions.
    always_comb begin
        complete_s  = sin_valid && !sin_sof && (state_r == ST_FILL) && (idx_r == IDX_LAST);
        handshake_s = cw_valid_r && cw_ready;
        load_s      = complete_s && (!cw_valid_r || cw_ready);
        drop_s      = complete_s && cw_valid_r && !cw_ready;
    end

    // Framing FSM: hunts for sof, then fills bit positions; a sof mid-frame restarts capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_HUNT;
            idx_r      <= IDX_ZERO;
            frame_r    <= {N{1'b0}};
            sync_err_r <= 1'b0;
        end else begin
            sync_err_r <= 1'b0;
            if (sin_valid) begin
                if (sin_sof) begin
                    frame_r[0] <= sin_data;
                    idx_r      <= IDX_ONE;
                    sync_err_r <= (state_r == ST_FILL);
                    state_r    <= ST_FILL;
                end else begin
                    case (state_r)
                        ST_HUNT: begin
                            state_r <= ST_HUNT;
                        end
                        ST_FILL: begin
                            frame_r[idx_r] <= sin_data;
                            if (idx_r == IDX_LAST) begin
                                idx_r   <= IDX_ZERO;
                                state_r <= ST_HUNT;
                            end else begin
                                idx_r <= idx_r + IDX_ONE;
                            end
                        end
                        default: begin
                            idx_r   <= IDX_ZERO;
                            state_r <= ST_HUNT;
                        end
                    endcase
                end
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // One-entry output register: a finished frame loads when empty or draining, otherwise it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_valid_r <= 1'b0;
            cw_data_r  <= {N{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= drop_s;
            if (load_s) begin
                cw_data_r  <= word_s;
                cw_valid_r <= 1'b1;
            end else if (handshake_s) begin
                cw_valid_r <= 1'b0;
            end else begin
                cw_valid_r <= cw_valid_r;
            end
        end
    end

    assign cw_valid = cw_valid_r;
    assign cw_data  = cw_data_r;
    assign overflow = overflow_r;
    assign sync_err = sync_err_r;

    cw_deserializer_checker #(
        .N  (N),
        .CW (CW)
    ) u_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (idx_r),
        .cw_valid (cw_valid_r),
        .cw_ready (cw_ready),
        .cw_data  (cw_data_r)
    );

endmodule

// Invariants of the deserializer: bit index stays in range and a stalled codeword is held.
module cw_deserializer_checker #(
    parameter int N  = 31,
    parameter int CW = $clog2(N)
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] idx,
    input logic          cw_valid,
    input logic          cw_ready,
    input logic [0:N-1]  cw_data
);

    localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);

    idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        idx <= IDX_LAST);

    stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
        (cw_valid && !cw_ready) |=> (cw_valid && $stable(cw_data)));

endmodule
